// File: rtl/maxpool_relu.sv
// 2x2 stride-2 signed max pooling over three lockstep 12-bit channels, with a
// one-entry-per-pooled-column line buffer. Optional ReLU clamp: MAXPOOL_RELU_EN.
module maxpool_relu #(
    parameter int unsigned CONV_BIT       = 12,
    parameter int unsigned HALF_WIDTH     = 12,
    parameter int unsigned HALF_HEIGHT    = 12,
    parameter int unsigned HALF_WIDTH_BIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_in,
    input  logic [CONV_BIT-1:0] conv_out_1,
    input  logic [CONV_BIT-1:0] conv_out_2,
    input  logic [CONV_BIT-1:0] conv_out_3,
    output logic [CONV_BIT-1:0] max_value_1,
    output logic [CONV_BIT-1:0] max_value_2,
    output logic [CONV_BIT-1:0] max_value_3,
    output logic                valid_out_relu
);

    localparam int unsigned COL_BIT = HALF_WIDTH_BIT + 1;
    localparam int unsigned ROW_BIT = $clog2(2 * HALF_HEIGHT);
    localparam int unsigned NCH     = 3;

    typedef enum logic [1:0] {
        EVEN_FIRST  = 2'b00,
        EVEN_SECOND = 2'b01,
        ODD_FIRST   = 2'b10,
        ODD_SECOND  = 2'b11
    } phase_t;

    logic [COL_BIT-1:0]        col_cnt, col_nxt;
    logic [ROW_BIT-1:0]        row_cnt, row_nxt;
    phase_t                    phase;
    logic [HALF_WIDTH_BIT-1:0] addr;

    logic signed [CONV_BIT-1:0] sample    [NCH];
    logic signed [CONV_BIT-1:0] hold_q    [NCH];
    logic signed [CONV_BIT-1:0] hold_nxt  [NCH];
    logic signed [CONV_BIT-1:0] max_q     [NCH];
    logic signed [CONV_BIT-1:0] max_nxt   [NCH];
    logic signed [CONV_BIT-1:0] buf_wdata [NCH];
    logic signed [CONV_BIT-1:0] line_buf  [NCH][HALF_WIDTH];
    logic                       buf_we;
    logic                       pulse_nxt;

    function automatic logic signed [CONV_BIT-1:0] smax(
        input logic signed [CONV_BIT-1:0] a,
        input logic signed [CONV_BIT-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [CONV_BIT-1:0] clamp(
        input logic signed [CONV_BIT-1:0] v
    );
`ifdef MAXPOOL_RELU_EN
        return v[CONV_BIT-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign sample[0] = conv_out_1;
    assign sample[1] = conv_out_2;
    assign sample[2] = conv_out_3;
    assign phase     = phase_t'({row_cnt[0], col_cnt[0]});
    assign addr      = col_cnt[COL_BIT-1:1];

    // State register: raster counters whose low bits form the phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else begin
            col_cnt <= col_nxt;
            row_cnt <= row_nxt;
        end
    end

    // Next-state: advance only on valid samples, wrap rows at frame end
    always_comb begin
        col_nxt = col_cnt;
        row_nxt = row_cnt;
        if (valid_in) begin
            if (col_cnt == COL_BIT'(2 * HALF_WIDTH - 1)) begin
                col_nxt = '0;
                if (row_cnt == ROW_BIT'(2 * HALF_HEIGHT - 1)) begin
                    row_nxt = '0;
                end else begin
                    row_nxt = row_cnt + ROW_BIT'(1);
                end
            end else begin
                col_nxt = col_cnt + COL_BIT'(1);
            end
        end
    end

    // Output/datapath decode per phase
    always_comb begin
        buf_we    = 1'b0;
        pulse_nxt = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            hold_nxt[ch]  = hold_q[ch];
            max_nxt[ch]   = max_q[ch];
            buf_wdata[ch] = smax(hold_q[ch], sample[ch]);
        end
        if (valid_in) begin
            unique case (phase)
                EVEN_FIRST: begin
                    for (int ch = 0; ch < NCH; ch++) hold_nxt[ch] = sample[ch];
                end
                EVEN_SECOND: begin
                    buf_we = 1'b1;
                end
                ODD_FIRST: begin
                    for (int ch = 0; ch < NCH; ch++)
                        hold_nxt[ch] = smax(line_buf[ch][addr], sample[ch]);
                end
                ODD_SECOND: begin
                    pulse_nxt = 1'b1;
                    for (int ch = 0; ch < NCH; ch++)
                        max_nxt[ch] = clamp(smax(hold_q[ch], sample[ch]));
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NCH; ch++) begin
                hold_q[ch] <= '0;
                max_q[ch]  <= '0;
            end
            valid_out_relu <= 1'b0;
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                hold_q[ch] <= hold_nxt[ch];
                max_q[ch]  <= max_nxt[ch];
            end
            valid_out_relu <= pulse_nxt;
        end
    end

    // Line buffer is always rewritten in an even row before the odd row reads it
    always_ff @(posedge clk) begin
        if (buf_we) begin
            for (int ch = 0; ch < NCH; ch++) line_buf[ch][addr] <= buf_wdata[ch];
        end
    end

    assign max_value_1 = max_q[0];
    assign max_value_2 = max_q[1];
    assign max_value_3 = max_q[2];

endmodule

// File: tb/tb_maxpool_relu.sv
// Directed bench for maxpool_relu: ramp frames, gaps, negative window, resets.
module tb_maxpool_relu;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [11:0] conv_out_1, conv_out_2, conv_out_3;
    logic [11:0] max_value_1, max_value_2, max_value_3;
    logic        valid_out_relu;

    typedef struct {
        int e1;
        int e2;
        int e3;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   pulse_cnt = 0;
    int   pos_r     = 0;
    int   pos_c     = 0;
    logic exp_pulse = 1'b0;

    maxpool_relu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_in      (valid_in),
        .conv_out_1    (conv_out_1),
        .conv_out_2    (conv_out_2),
        .conv_out_3    (conv_out_3),
        .max_value_1   (max_value_1),
        .max_value_2   (max_value_2),
        .max_value_3   (max_value_3),
        .valid_out_relu(valid_out_relu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int relu(input int v);
`ifdef MAXPOOL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // Pulse timing and data check, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            check("pulse_timing", int'(valid_out_relu), int'(exp_pulse));
            if (valid_out_relu) begin
                pulse_cnt++;
                if (exp_q.size() == 0) begin
                    check("spurious_pulse", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ch1", int'($signed(max_value_1)), e.e1);
                    check("ch2", int'($signed(max_value_2)), e.e2);
                    check("ch3", int'($signed(max_value_3)), e.e3);
                end
            end
        end
    end

    task automatic send(input int a, input int b, input int c);
        logic completes;
        completes  = (pos_r % 2 == 1) && (pos_c % 2 == 1);
        valid_in   = 1'b1;
        conv_out_1 = 12'(a);
        conv_out_2 = 12'(b);
        conv_out_3 = 12'(c);
        pos_c++;
        if (pos_c == 24) begin
            pos_c = 0;
            pos_r = (pos_r == 23) ? 0 : pos_r + 1;
        end
        @(posedge clk);
        #1;
        exp_pulse = completes;
        valid_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            valid_in = 1'b0;
            @(posedge clk);
            #1;
            exp_pulse = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        valid_in  = 1'b0;
        exp_pulse = 1'b0;
        #2;
        check("rst_valid", int'(valid_out_relu), 0);
        check("rst_ch1", int'(max_value_1), 0);
        check("rst_ch2", int'(max_value_2), 0);
        check("rst_ch3", int'(max_value_3), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        pos_r = 0;
        pos_c = 0;
    endtask

    // Ramp samples: ch1 = v+o, ch2 = -(v+o), ch3 = 575-v with v = row*24+col
    task automatic ramp(input int o, input int gap, input int nsamp);
        for (int i = 0; i < nsamp; i++) begin
            int r, c, v;
            exp_t e;
            r = i / 24;
            c = i % 24;
            v = r * 24 + c;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                e.e1 = relu(v + o);
                e.e2 = relu(-(v - 25 + o));
                e.e3 = relu(575 - (v - 25));
                exp_q.push_back(e);
            end
            send(v + o, -(v + o), 575 - v);
            idle(gap);
        end
    endtask

    initial begin
        exp_t e;
        rst_n      = 1'b0;
        valid_in   = 1'b0;
        conv_out_1 = '0;
        conv_out_2 = '0;
        conv_out_3 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("init_valid", int'(valid_out_relu), 0);
        check("init_ch1", int'(max_value_1), 0);
        rst_n = 1'b1;

        idle(20);
        check("idle_pulses", pulse_cnt, 0);
        check("idle_ch2", int'(max_value_2), 0);

        pulse_cnt = 0;
        ramp(0, 0, 576);
        idle(1);
        check("ramp_pulses", pulse_cnt, 144);
        check("ramp_last_ch1", int'($signed(max_value_1)), 575);
        check("ramp_q_empty", exp_q.size(), 0);

        pulse_cnt = 0;
        ramp(0, 3, 576);
        idle(1);
        check("gap_pulses", pulse_cnt, 144);
        check("gap_q_empty", exp_q.size(), 0);

        send(-5, -1, 100);
        send(-3, 4, 200);
        for (int i = 2; i < 24; i++) send(0, 0, 0);
        send(-7, 0, 300);
        e.e1 = relu(-2);
        e.e2 = 4;
        e.e3 = 300;
        exp_q.push_back(e);
        send(-2, 2, 50);
        idle(1);
`ifdef MAXPOOL_RELU_EN
        check("neg_ch1_relu", int'(max_value_1), 0);
`else
        check("neg_ch1_raw", int'(max_value_1), 12'hFFE);
`endif
        check("neg_q_empty", exp_q.size(), 0);
        do_reset();

        ramp(0, 0, 300);
        check("mid_q_empty", exp_q.size(), 0);
        do_reset();
        pulse_cnt = 0;
        ramp(0, 0, 576);
        idle(1);
        check("post_rst_pulses", pulse_cnt, 144);

        pulse_cnt = 0;
        ramp(0, 0, 576);
        ramp(1000, 0, 576);
        idle(1);
        check("b2b_pulses", pulse_cnt, 288);
        check("b2b_last_ch1", int'($signed(max_value_1)), 1575);
        check("b2b_q_empty", exp_q.size(), 0);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
